// File: rtl/down_counter_timer_pkg.sv
// Shared types and limits for the loadable down-counter timer.
package down_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter with run/hold control and a one-cycle done pulse.
// Define DOWN_CNT_AUTO_RELOAD_EN to restart from the last loaded value instead of stopping.
module down_counter_timer
  import down_cnt_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] counter_down,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("down_counter_timer: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_done;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_done_nxt;

`ifdef DOWN_CNT_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload_q;
`endif

  // Load wins over everything except reset; DONE always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (load) begin
      w_cnt_nxt   = load_val;
      w_state_nxt = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        RUN: begin
          if (en && r_cnt == ONE) begin
            w_done_nxt = 1'b1;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
            w_cnt_nxt   = r_reload_q;
            w_state_nxt = RUN;
`else
            w_cnt_nxt   = '0;
            w_state_nxt = DONE;
`endif
          end else if (en && r_cnt != '0) begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
      r_reload_q <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
      if (load) r_reload_q <= load_val;
`endif
    end
  end

  assign counter_down = r_cnt;
  assign zero         = (r_cnt == '0);
  assign busy         = (r_state == RUN);
  assign done         = r_done;
  assign dbg_state    = r_state;

endmodule
